tt_um_brs_max_sched: RTL
========================

# tt_um_brs_max_sched

Frame-based running-maximum scheduler for the team's byte-compare datapath. It sequences one shared unsigned 8-bit comparator over a stream of samples on `ui_in`, framed by start/valid/last strobes on `uio_in`. It holds the frame maximum in a result register and signals busy, done and overflow on `uio_out`. It sits as a Tiny Tapeout top-level tile using the standard `tt_um_` pin set.

## Interface
- `MAX_LEN`, default 16: maximum samples per frame, range 2..255.
- `CNT_W`, default 8: sample counter width; must satisfy 2^CNT_W > MAX_LEN.
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ena`  in  1  power-good; ignored.
- `ui_in`  in  8  sample data, unsigned.
- `uio_in`  in  8  control strobes:
  - [0] `start`
  - [1] `valid`
  - [2] `last`
  - [3] `sel`; used only when `BRS_ARGMAX_EN` is defined.
  - [7:4] ignored.
- `uo_out`  out  8  result register: running/final max, or the argmax index (see Configuration).
- `uio_out`  out  8  status:
  - [7] `done`
  - [6] `busy`
  - [5] `ovf`
  - [4:0] tied to 0.
- `uio_oe`  out  8  constant 8'hE0.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `busy`=0, `done`=0.
  - `valid` and `last` are ignored.
  - `start`=1 goes to ACCUM.
- Entry to ACCUM, from any state on `start`=1:
  - max := 0, cnt := 0, `done` := 0, `ovf` := 0.
  - The start cycle never consumes a sample, even if `valid`=1.
- ACCUM, `valid`=1, `start`=0:
  - Sample accepted.
  - If `ui_in` > max (strict unsigned), max := `ui_in`. Ties keep the earlier value.
  - cnt := cnt+1.
- ACCUM exit:
  - `valid`&`last` goes to DONE with `ovf`=0.
  - Otherwise an accepted sample with cnt == MAX_LEN-1 goes to DONE with `ovf`=1. That sample is still included in the max.
- ACCUM, `valid`=0: hold all state. `last` without `valid` is ignored.
- `start`=1 in ACCUM: abort and restart. The partial frame is discarded.
- DONE:
  - `done`=1, `busy`=0; result and `ovf` are held.
  - `start` goes to ACCUM; otherwise the state stays in DONE.
  - `valid` and `last` are ignored.
- `busy`=1 exactly while in ACCUM.
- Reset (`rst_n`=0 at a clock edge), including mid-frame:
  - state := IDLE, max := 0, cnt := 0.
  - `uo_out`=0, `done`=0, `busy`=0, `ovf`=0.

## Timing
- All outputs are registered; there is no combinational input-to-output path except the `sel` mux (Configuration).
- Latency 1: `uo_out` reflects sample k on the cycle after k is accepted.
- `done` rises the cycle after the terminating sample; `busy` falls in the same cycle.
- `start` to `busy`=1: 1 cycle.
- Throughput: one sample per cycle, back-to-back `valid` allowed.
- The counter never wraps: the overflow terminate fires first.

## Configuration
- Macro `BRS_ARGMAX_EN`.
- Defined:
  - Adds an index register `idx` (CNT_W bits), cleared with max.
  - `idx` := cnt on each strict update.
  - `uo_out` = `sel` ? `idx`[7:0] : max. `sel` is a live mux, so it has no latency.
- Undefined: no `idx` register; `uio_in`[3] is ignored and `uo_out` is always max.

## Structure
- Package `brs_pkg`:
  - State encoding: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - `uio` bit-position constants: START=0, VALID=1, LAST=2, SEL=3, OVF=5, BUSY=6, DONE=7.
  - `UIO_OE_MASK`=8'hE0.
- Sub-module `brs_max_cmp`: combinational strict unsigned compare-select. Outputs `gt` and `next_max`; this is the shared datapath instance.
- Top level holds the FSM, counter, result and status registers.

## Test plan
- Reset mid-frame: feed 3 samples, assert `rst_n`=0 for one cycle. Expect `uo_out`=0, status=0, state IDLE. `valid` pulses afterward cause no change.
- Normal frame: start, then 10,200,37,200(last). Expect `uo_out`=200; `done`=1 one cycle after the last sample; `ovf`=0; with the macro and `sel`=1, `uo_out`=1.
- Overflow: MAX_LEN=16, start, then 16 samples 0..15 with no `last`. Expect DONE, `ovf`=1, `uo_out`=15.
- Gaps and simultaneous events:
  - Sequence: start with `valid`=1 and `ui_in`=99, then `valid`=0 for 3 cycles, then 5(last).
  - Expect result 5: the start-cycle sample is dropped.
  - `last` pulses without `valid` are ignored.
- Restart: abort mid-frame with `start`, then frame 7,3(last). Expect 7. Then `start` from DONE with frame 0(last) gives `uo_out`=0, `done` re-asserted.

Source files
------------

// File: rtl/brs_pkg.sv
// Shared types and constants for the byte running-maximum scheduler.
// FSM state encoding, uio strobe/status bit positions, output-enable mask.
package brs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } brs_state_e;

  localparam int BIT_START = 0;
  localparam int BIT_VALID = 1;
  localparam int BIT_LAST  = 2;
  localparam int BIT_SEL   = 3;
  localparam int BIT_OVF   = 5;
  localparam int BIT_BUSY  = 6;
  localparam int BIT_DONE  = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hE0;

endpackage

// File: rtl/brs_max_cmp.sv
// Shared compare-select: strict unsigned greater-than against the running max.
// Ties keep the held value so the earliest maximum wins.
module brs_max_cmp (
  input  logic [7:0] sample_i,
  input  logic [7:0] max_i,
  output logic       gt_o,
  output logic [7:0] next_max_o
);

  assign gt_o       = sample_i > max_i;
  assign next_max_o = gt_o ? sample_i : max_i;

endmodule

// File: rtl/tt_um_brs_max_sched.sv
// Frame-based running-maximum scheduler tile (FSM, counter, result, status).
// Optional argmax index register and live sel mux under BRS_ARGMAX_EN.
module tt_um_brs_max_sched
  import brs_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  brs_state_e       state_q, state_d;
  logic [7:0]       max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic       start, valid, last;
  logic       gt;
  logic [7:0] next_max;
  logic       accept;

  assign start  = uio_in[BIT_START];
  assign valid  = uio_in[BIT_VALID];
  assign last   = uio_in[BIT_LAST];
  assign accept = (state_q == ACCUM) && valid && !start;

  brs_max_cmp u_cmp (
    .sample_i   (ui_in),
    .max_i      (max_q),
    .gt_o       (gt),
    .next_max_o (next_max)
  );

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = ACCUM;
      max_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      max_d = next_max;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        state_d = DONE;
        ovf_d   = 1'b0;
      end else if (cnt_q == LAST_CNT) begin
        // Frame hit its length cap: terminate before the counter can wrap
        state_d = DONE;
        ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      max_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BRS_ARGMAX_EN
  logic [CNT_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (start) begin
      idx_d = '0;
    end else if (accept && gt) begin
      idx_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign uo_out = uio_in[BIT_SEL] ? 8'(idx_q) : max_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};
`else
  assign uo_out = max_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4], uio_in[BIT_SEL], gt};
`endif

  always_comb begin
    uio_out           = '0;
    uio_out[BIT_DONE] = (state_q == DONE);
    uio_out[BIT_BUSY] = (state_q == ACCUM);
    uio_out[BIT_OVF]  = ovf_q;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule
